// File: rtl/llc_cmd_sequencer.sv
// Trace-command sequencer feeding the LLC: FIFO-buffered, one command per ISSUE/WAIT pair,
// eviction-only replays. Define LLC_SEQ_STATS_EN to add the stat_* counter outputs.
module llc_cmd_sequencer #(
    parameter int DEPTH      = 8,
    parameter int MAX_REPLAY = 3,
    parameter int NOP_OP     = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_op,
    input  logic        [31:0] in_addr,
    output logic signed [31:0] llc_op,
    output logic        [31:0] llc_addr,
    input  logic        [31:0] llc_hits,
    input  logic        [31:0] llc_misses,
    output logic               busy,
    output logic               err
`ifdef LLC_SEQ_STATS_EN
    ,
    output logic        [31:0] stat_issued,
    output logic        [31:0] stat_replays,
    output logic        [31:0] stat_dropped
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MAX_REPLAY > 0) ? $clog2(MAX_REPLAY + 1) : 1;
    localparam logic [CW-1:0] MAX_R = CW'(MAX_REPLAY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state, state_n;

    logic signed [31:0] mem_op   [DEPTH];
    logic        [31:0] mem_addr [DEPTH];
    logic [AW:0]        wptr, rptr;
    logic               empty, full;
    logic               accept, op_ok, push, drop_in;

    logic signed [31:0] cmd_op;
    logic        [31:0] cmd_addr;
    logic        [31:0] snap_hits, snap_misses;
    logic [CW-1:0]      cnt;
    logic               pop, replay, replay_cond, limit_drop;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign in_ready = !full && !reset;
    assign accept   = in_valid && in_ready;
    assign op_ok    = (in_op >= 0 && in_op <= 6) || (in_op == 8) || (in_op == 9);
    assign push     = accept && op_ok;
    assign drop_in  = accept && !op_ok;

    // Same counters as the snapshot means the LLC only evicted; the command must be re-sent.
    assign replay_cond = (cmd_op >= 0) && (cmd_op <= 2) &&
                         (llc_hits == snap_hits) && (llc_misses == snap_misses);

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        replay     = 1'b0;
        limit_drop = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                if (replay_cond && (cnt < MAX_R)) begin
                    replay  = 1'b1;
                    state_n = S_ISSUE;
                end else begin
                    limit_drop = replay_cond;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = S_ISSUE;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign llc_op   = (state == S_ISSUE) ? cmd_op : 32'(NOP_OP);
    assign llc_addr = cmd_addr;
    assign busy     = !empty || (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wptr[AW-1:0]]   <= in_op;
            mem_addr[wptr[AW-1:0]] <= in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wptr        <= '0;
            rptr        <= '0;
            cmd_op      <= 32'(NOP_OP);
            cmd_addr    <= '0;
            snap_hits   <= '0;
            snap_misses <= '0;
            cnt         <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_n;
            if (push)
                wptr <= wptr + (AW+1)'(1);
            if (pop) begin
                cmd_op      <= mem_op[rptr[AW-1:0]];
                cmd_addr    <= mem_addr[rptr[AW-1:0]];
                rptr        <= rptr + (AW+1)'(1);
                snap_hits   <= llc_hits;
                snap_misses <= llc_misses;
                cnt         <= '0;
            end
            if (replay) begin
                snap_hits   <= llc_hits;
                snap_misses <= llc_misses;
                cnt         <= cnt + CW'(1);
            end
            if (limit_drop)
                err <= 1'b1;
        end
    end

`ifdef LLC_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued  <= '0;
            stat_replays <= '0;
            stat_dropped <= '0;
        end else begin
            if (state == S_ISSUE)
                stat_issued <= stat_issued + 32'd1;
            if (replay)
                stat_replays <= stat_replays + 32'd1;
            // An input discard and a replay-limit drop can land on the same edge.
            stat_dropped <= stat_dropped + 32'(drop_in) + 32'(limit_drop);
        end
    end
`endif

endmodule

// File: tb/tb_llc_cmd_sequencer.sv
// Scoreboard bench for llc_cmd_sequencer: directed pushes queue expected LLC issues,
// a negedge monitor compares every non-NOP cycle; a small LLC model drives the counters.
module tb_llc_cmd_sequencer;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_op = '0;
    logic        [31:0] in_addr = '0;
    logic signed [31:0] llc_op;
    logic        [31:0] llc_addr;
    logic        [31:0] llc_hits = '0;
    logic        [31:0] llc_misses = '0;
    logic               busy;
    logic               err;
`ifdef LLC_SEQ_STATS_EN
    logic        [31:0] stat_issued, stat_replays, stat_dropped;
`endif

    llc_cmd_sequencer #(.DEPTH(8), .MAX_REPLAY(3), .NOP_OP(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_addr    (in_addr),
        .llc_op     (llc_op),
        .llc_addr   (llc_addr),
        .llc_hits   (llc_hits),
        .llc_misses (llc_misses),
        .busy       (busy),
        .err        (err)
`ifdef LLC_SEQ_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_replays (stat_replays),
        .stat_dropped (stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] op;
        logic        [31:0] addr;
    } cmd_t;

    cmd_t exp_q[$];
    int   resp_q[$];     // per-issue LLC response: 0 = counters unchanged, 1 = miss, 2 = hit
    int   issue_t[$];
    int   n_issued = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin : llc_model
        int r;
        if (!reset && llc_op != 9) begin
            r = (resp_q.size() != 0) ? resp_q.pop_front() : 1;
            if (r == 1) llc_misses <= llc_misses + 32'd1;
            else if (r == 2) llc_hits <= llc_hits + 32'd1;
        end
    end

    always @(negedge clk) begin : monitor
        cmd_t e;
        if (!reset && llc_op != 9) begin
            n_issued++;
            issue_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got op %0d addr 0x%0h expected none", llc_op, llc_addr);
            end else begin
                e = exp_q.pop_front();
                check("issue_op", llc_op, e.op);
                check("issue_addr", llc_addr, e.addr);
            end
        end
    end

    // n_nochg issues with unchanged counters, then one miss if with_final.
    task automatic push(input int op, input logic [31:0] addr, input int n_nochg,
                        input bit with_final, output int waits);
        cmd_t c;
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        waits    = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if ((op >= 0 && op <= 6) || op == 8 || op == 9) begin
            c.op   = op;
            c.addr = addr;
            for (int i = 0; i < n_nochg; i++) begin
                exp_q.push_back(c);
                resp_q.push_back(0);
            end
            if (with_final) begin
                exp_q.push_back(c);
                resp_q.push_back(1);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
        check({name, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n0;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_llc_op", llc_op, 32'd9);
        check("rst_llc_addr", llc_addr, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single command: ISSUE 1 cycle later, idle 3 cycles after acceptance.
        push(0, 32'h0000_1000, 0, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;
        check("single_busy", {31'd0, busy}, 32'd0);
        check("single_err", {31'd0, err}, 32'd0);
        check("single_pending", exp_q.size(), 32'd0);

        // Back-to-back burst issues every 2 cycles.
        issue_t.delete();
        push(3, 32'h0000_2000, 0, 1'b1, w); check("burst_ready0", w, 0);
        push(4, 32'h0000_2040, 0, 1'b1, w); check("burst_ready1", w, 0);
        push(5, 32'h0000_2080, 0, 1'b1, w); check("burst_ready2", w, 0);
        push(6, 32'h0000_20c0, 0, 1'b1, w); check("burst_ready3", w, 0);
        wait_idle("burst_drain");
        check("burst_count", issue_t.size(), 32'd4);
        for (int i = 1; i < issue_t.size(); i++)
            check("burst_spacing", issue_t[i] - issue_t[i-1], 32'd2);

        // Two eviction-only cycles, then completion: three identical issues.
        push(1, 32'h0040_0000, 2, 1'b1, w);
        wait_idle("replay_drain");
        check("replay_err", {31'd0, err}, 32'd0);
`ifdef LLC_SEQ_STATS_EN
        check("stat_replays_2", stat_replays, 32'd2);
        check("stat_issued_8", stat_issued, 32'd8);
`endif

        // Invalid ops are accepted and discarded.
        push(7, 32'h0000_3000, 0, 1'b0, w);
        push(12, 32'h0000_3040, 0, 1'b0, w);
        push(5, 32'h0000_3080, 0, 1'b1, w);
        wait_idle("invalid_drain");
`ifdef LLC_SEQ_STATS_EN
        check("stat_dropped_2", stat_dropped, 32'd2);
        check("stat_issued_9", stat_issued, 32'd9);
`endif

        // Replay limit stalls pops for 8 cycles while the FIFO fills.
        push(0, 32'h0000_5000, 4, 1'b0, w);
        for (int i = 0; i < 8; i++) begin
            push(i % 7, 32'h0000_6000 + 32'(i) * 32'h40, 0, 1'b1, w);
            check("fill_ready", w, 0);
        end
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        push(8, 32'h0000_7000, 0, 1'b1, w);
        check("full_release_wait", w, 1);
        wait_idle("limit_drain");
        check("limit_err", {31'd0, err}, 32'd1);
`ifdef LLC_SEQ_STATS_EN
        check("stat_replays_5", stat_replays, 32'd5);
        check("stat_dropped_3", stat_dropped, 32'd3);
        check("stat_issued_22", stat_issued, 32'd22);
`endif

        // Reset during WAIT of a replay with three commands queued.
        n0 = n_issued;
        push(1, 32'h0000_8000, 2, 1'b0, w);
        push(3, 32'h0000_8040, 0, 1'b0, w);
        push(4, 32'h0000_8080, 0, 1'b0, w);
        push(5, 32'h0000_80c0, 0, 1'b0, w);
        n = 0;
        while (!((n_issued - n0) >= 2 && llc_op == 9) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("reset_reach_wait", n_issued - n0, 32'd2);
        reset = 1'b1;
        exp_q.delete();
        resp_q.delete();
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("reset_llc_op", llc_op, 32'd9);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
`ifdef LLC_SEQ_STATS_EN
        check("reset_stat_issued", stat_issued, 32'd0);
        check("reset_stat_replays", stat_replays, 32'd0);
        check("reset_stat_dropped", stat_dropped, 32'd0);
`endif
        reset = 1'b0;
        n0 = n_issued;
        repeat (10) @(posedge clk);
        #1;
        check("reset_no_issue", n_issued - n0, 32'd0);
        check("reset_busy_after", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
